// File: rtl/write_back_pipe.sv
// Write-back stage: selects/extends a result at accept and holds up to two
// pending register-file writes in order, with a forwarding query port.
module write_back_pipe #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 4,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    localparam int SEL_W   = $clog2(NSRC),
    localparam int OFF_W   = $clog2(WIDTH / 8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_we,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NSRC*WIDTH-1:0]   in_src,
    input  logic [1:0]              in_ld_size,
    input  logic                    in_ld_signed,
    input  logic [OFF_W-1:0]        in_ld_off,
    output logic                    rf_valid,
    input  logic                    rf_ready,
    output logic [ADDR_W-1:0]       rf_addr,
    output logic [WIDTH-1:0]        rf_data,
    input  logic [ADDR_W-1:0]       q_addr,
    output logic                    q_hit,
    output logic [WIDTH-1:0]        q_data,
    output logic [1:0]              count
);

    logic [ADDR_W-1:0] e_addr [2];
    logic [WIDTH-1:0]  e_data [2];
    logic [1:0]        cnt;
    logic [WIDTH-1:0]  shifted, word_ext, ld_val, res;
    logic              accept, enq, pop, q_zero, hit0, hit1;

    assign shifted = in_src[WIDTH-1:0] >> {in_ld_off, 3'b000};

    // A 32-bit load only needs extending when the datapath is wider.
    generate
        if (WIDTH > 32) begin : g_wide
            assign word_ext = {{(WIDTH-32){in_ld_signed & shifted[31]}}, shifted[31:0]};
        end else begin : g_narrow
            assign word_ext = shifted;
        end
    endgenerate

    always_comb begin
        ld_val = shifted;
        case (in_ld_size)
            2'b00:   ld_val = {{(WIDTH-8){in_ld_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_val = {{(WIDTH-16){in_ld_signed & shifted[15]}}, shifted[15:0]};
            2'b10:   ld_val = word_ext;
            default: ld_val = shifted;
        endcase
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        res = '0;
        if (in_sel == '0) res = ld_val;
        for (int k = 1; k < NSRC; k++)
            if (in_sel == SEL_W'(k)) res = in_src[k*WIDTH +: WIDTH];
    end

    assign in_ready = (cnt < 2'd2);
    assign rf_valid = (cnt != 2'd0);
    assign accept   = in_valid & in_ready & ~flush;
    assign enq      = accept & in_we & ~((ZERO_REG != 0) && (in_addr == '0));
    assign pop      = rf_valid & rf_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
            end
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({enq, pop})
                2'b10: begin
                    e_addr[cnt[0]] <= in_addr;
                    e_data[cnt[0]] <= res;
                    cnt            <= cnt + 2'd1;
                end
                2'b01: begin
                    e_addr[0] <= e_addr[1];
                    e_data[0] <= e_data[1];
                    cnt       <= cnt - 2'd1;
                end
                // Push with pop only happens at one entry: new item replaces head.
                2'b11: begin
                    e_addr[0] <= in_addr;
                    e_data[0] <= res;
                end
                default: ;
            endcase
        end
    end

    assign count   = cnt;
    assign rf_addr = rf_valid ? e_addr[0] : '0;
    assign rf_data = rf_valid ? e_data[0] : '0;

    assign q_zero = (ZERO_REG != 0) && (q_addr == '0);
    assign hit1   = (cnt == 2'd2) && (e_addr[1] == q_addr);
    assign hit0   = (cnt != 2'd0) && (e_addr[0] == q_addr);
    assign q_hit  = (hit0 | hit1) & ~q_zero;
    assign q_data = q_zero ? '0 : hit1 ? e_data[1] : hit0 ? e_data[0] : '0;

endmodule

// File: tb/tb_write_back_pipe.sv
// Randomized bench for write_back_pipe (WIDTH=32, NSRC=5) against a queue model.
module tb_write_back_pipe;
    localparam int W = 32, NS = 5, AW = 5;

    logic clk = 1'b0, reset, flush, in_valid, in_we, in_ld_signed, rf_ready;
    logic [AW-1:0] in_addr, q_addr, rf_addr;
    logic [2:0] in_sel;
    logic [NS*W-1:0] in_src;
    logic [1:0] in_ld_size, count;
    logic [1:0] in_ld_off;
    logic in_ready, rf_valid, q_hit;
    logic [W-1:0] rf_data, q_data;

    int nchk = 0, nerr = 0;
    bit run = 0;

    typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } ent_t;
    ent_t mq[$];

    write_back_pipe #(.WIDTH(W), .NSRC(NS), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_addr(in_addr), .in_sel(in_sel), .in_src(in_src),
        .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_ld_off(in_ld_off),
        .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_data(rf_data),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count));

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Result value straight from the load/select rules.
    function automatic logic [W-1:0] exp_res();
        int s = int'(in_sel);
        int bits;
        logic [63:0] v, m;
        if (s >= NS) return '0;
        if (s != 0) return in_src[s*W +: W];
        v = 64'(in_src[W-1:0]) >> (int'(in_ld_off) * 8);
        bits = 8 << in_ld_size;
        if (bits >= 32) return v[W-1:0];
        m = (64'd1 << bits) - 64'd1;
        v = v & m;
        if (in_ld_signed && v[bits-1]) v = v | ~m;
        return v[W-1:0];
    endfunction

    task automatic model_step();
        bit acc, popd;
        if (reset || flush) begin
            mq.delete();
            return;
        end
        acc  = in_valid && mq.size() < 2;
        popd = mq.size() > 0 && rf_ready;
        if (popd) void'(mq.pop_front());
        if (acc && in_we && in_addr != 0) mq.push_back('{in_addr, exp_res()});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            logic hit;
            logic [W-1:0] qd;
            hit = 0;
            qd = '0;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (!hit && q_addr != 0 && mq[i].a == q_addr) begin
                    hit = 1;
                    qd = mq[i].d;
                end
            chk("count", count, mq.size());
            chk("in_ready", in_ready, mq.size() < 2);
            chk("rf_valid", rf_valid, mq.size() > 0);
            chk("rf_addr", rf_addr, mq.size() > 0 ? mq[0].a : '0);
            chk("rf_data", rf_data, mq.size() > 0 ? mq[0].d : '0);
            chk("q_hit", q_hit, hit);
            chk("q_data", q_data, qd);
        end
    end

    task automatic push(logic [AW-1:0] a, logic [2:0] sel, logic [W-1:0] v, logic we);
        in_valid = 1; in_we = we; in_addr = a; in_sel = sel;
        in_src[sel < NS ? sel*W : 0 +: W] = v;
        cyc();
        in_valid = 0;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_we = 0; in_addr = 0; in_sel = 0;
        in_src = '0; in_ld_size = 0; in_ld_signed = 0; in_ld_off = 0; rf_ready = 0; q_addr = 0;
        run = 1;
        cyc(); cyc();
        reset = 0;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_valid", rf_valid, 0);

        // Load byte, signed then unsigned
        in_ld_size = 2'b00; in_ld_signed = 1; in_ld_off = 1;
        push(5'd3, 3'd0, 32'h8000_FF00, 1);
        chk("lb_valid", rf_valid, 1);
        chk("lb_addr", rf_addr, 3);
        chk("lb_s_data", rf_data, 32'hFFFF_FFFF);
        rf_ready = 1; cyc(); rf_ready = 0;
        in_ld_signed = 0;
        push(5'd3, 3'd0, 32'h8000_FF00, 1);
        chk("lb_u_data", rf_data, 32'h0000_00FF);
        rf_ready = 1; cyc(); rf_ready = 0;

        // Back-pressure
        push(5'd4, 3'd1, 32'h11, 1);
        push(5'd5, 3'd1, 32'h22, 1);
        chk("bp_count", count, 2);
        chk("bp_in_ready", in_ready, 0);
        push(5'd6, 3'd1, 32'h33, 1);
        chk("bp_third", count, 2);
        chk("bp_head0", rf_data, 32'h11);
        rf_ready = 1; cyc();
        chk("bp_head1", rf_data, 32'h22);
        cyc(); rf_ready = 0;
        chk("bp_empty", count, 0);

        // Forwarding, then flush at count=2
        push(5'd7, 3'd1, 32'hAA, 1);
        push(5'd7, 3'd1, 32'hBB, 1);
        q_addr = 7; #1;
        chk("fw_hit", q_hit, 1);
        chk("fw_data", q_data, 32'hBB);
        q_addr = 8; #1;
        chk("fw_miss", q_hit, 0);
        chk("fw_miss_d", q_data, 0);
        flush = 1; in_valid = 1; in_we = 1; in_addr = 10; rf_ready = 1;
        cyc();
        flush = 0; in_valid = 0; rf_ready = 0;
        chk("fl_count", count, 0);
        chk("fl_valid", rf_valid, 0);

        // Zero register and no-write
        push(5'd0, 3'd1, 32'h55, 1);
        chk("z0_count", count, 0);
        push(5'd9, 3'd1, 32'h66, 0);
        chk("nw_count", count, 0);
        chk("nw_valid", rf_valid, 0);

        // Async reset between edges at count=1
        push(5'd12, 3'd1, 32'h77, 1);
        q_addr = 12;
        #2 reset = 1; mq.delete();
        #1;
        chk("ar_valid", rf_valid, 0);
        chk("ar_data", rf_data, 0);
        chk("ar_addr", rf_addr, 0);
        chk("ar_count", count, 0);
        chk("ar_qhit", q_hit, 0);
        chk("ar_ready", in_ready, 1);
        cyc(); reset = 0;

        // Generic and out-of-range source
        push(5'd13, 3'd2, 32'h1234_5678, 1);
        chk("src2", rf_data, 32'h1234_5678);
        rf_ready = 1; cyc(); rf_ready = 0;
        push(5'd14, 3'd6, 32'hDEAD_BEEF, 1);
        chk("src6_valid", rf_valid, 1);
        chk("src6_data", rf_data, 0);
        rf_ready = 1; cyc(); rf_ready = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 199) == 0);
            if (reset) mq.delete();
            flush        = ($urandom_range(0, 19) == 0);
            in_valid     = $urandom_range(0, 1);
            in_we        = ($urandom_range(0, 9) != 0);
            in_addr      = AW'($urandom_range(0, 15));
            in_sel       = 3'($urandom_range(0, 7));
            for (int k = 0; k < NS; k++) in_src[k*W +: W] = $urandom;
            in_ld_size   = 2'($urandom_range(0, 3));
            in_ld_signed = $urandom_range(0, 1);
            in_ld_off    = 2'($urandom_range(0, 3));
            rf_ready     = $urandom_range(0, 1);
            q_addr       = AW'($urandom_range(0, 15));
            cyc();
        end
        reset = 0;
        cyc();
        run = 0;
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/write_back_pipe.md
WRITE_BACK_PIPE -- requirements
Module: write_back_pipe

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, datapath width (32 or 64); NSRC, default 4, number of result sources (2..8); ADDR_W, default 5, register address width; ZERO_REG, default 1, address 0 is hard-wired and writes to it are discarded.
REQ-002 Derived widths SHALL be SEL_W = clog2(NSRC) and OFF_W = clog2(WIDTH/8).
REQ-003 Ports SHALL be:
  clk  in  1  rising-edge clock, the single clock for all state
  reset  in  1  asynchronous active-high reset
  flush  in  1  discard all pending entries
  in_valid  in  1  upstream result present
  in_ready  out  1  stage can accept
  in_we  in  1  result targets the register file
  in_addr  in  ADDR_W  destination register
  in_sel  in  SEL_W  source select
  in_src  in  NSRC*WIDTH  flattened sources; source k at bits [k*WIDTH +: WIDTH], source 0 is data memory
  in_ld_size  in  2  00 byte, 01 half, 10 word, 11 double
  in_ld_signed  in  1  sign-extend load
  in_ld_off  in  OFF_W  byte offset of load within source 0
  rf_valid  out  1  write pending at head
  rf_ready  in  1  register-file port granted
  rf_addr  out  ADDR_W  head destination
  rf_data  out  WIDTH  head data
  q_addr  in  ADDR_W  forwarding query address
  q_hit  out  1  query matches a pending entry
  q_data  out  WIDTH  data of matching entry
  count  out  2  occupancy 0..2

Function
REQ-004 Accept SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-005 The stage SHALL hold a 2-entry in-order queue; in_ready SHALL equal (count < 2).
REQ-006 Result SHALL be computed at accept and stored; in_sel >= NSRC SHALL yield zero.
REQ-007 For in_sel=0: source 0 SHALL be shifted right by in_ld_off*8, then the low 8/16/32/64 bits kept per in_ld_size, zero- or sign-extended to WIDTH per in_ld_signed.
REQ-008 Size 11 at WIDTH=32, and size 10 at WIDTH=32, SHALL pass all 32 bits unchanged (no extension).
REQ-009 For in_sel != 0 the selected source SHALL pass unmodified; ld fields ignored.
REQ-010 An accepted item with in_we=0, or in_addr=0 when ZERO_REG=1, SHALL be consumed without being enqueued.
REQ-011 rf_valid SHALL equal (count > 0); rf_addr/rf_data SHALL present the oldest entry.
REQ-012 Pop SHALL occur on a rising edge where rf_valid=1, rf_ready=1 and flush=0.
REQ-013 Latency: data accepted at edge t SHALL appear on rf_* in the cycle after t when queue was empty (1 cycle).
REQ-014 Simultaneous push and pop at count=1 SHALL leave count=1 with the new entry at head; at count=0 a push with no pop SHALL give count=1.
REQ-015 flush=1 SHALL set count to 0 at the next edge, overriding any push or pop in that cycle; in_ready remains combinational from count.
REQ-016 q_hit SHALL be 1 when any pending entry has address q_addr; q_data SHALL be the youngest matching entry's data, zero when q_hit=0; q_addr=0 with ZERO_REG=1 SHALL give q_hit=0.
REQ-017 rf_addr/rf_data SHALL be don't-care-free: zero when count=0.

Reset
REQ-018 reset=1 SHALL asynchronously set count=0, rf_valid=0, rf_addr=0, rf_data=0, q_hit=0, q_data=0, in_ready=1.
REQ-019 Reset asserted mid-operation SHALL discard all entries; no rf write SHALL be presented until a new accept after release.

Verification
REQ-020 Load byte: in_sel=0, src0=0x8000_FF00, size=00, signed=1, off=1, we=1, addr=3 -> next cycle rf_valid=1, rf_addr=3, rf_data=0xFFFF_FFFF; repeat signed=0 -> 0x0000_00FF.
REQ-021 Back-pressure: rf_ready=0, push addr 4 (0x11) and addr 5 (0x22) -> count=2, in_ready=0, third push ignored; rf_ready=1 -> pops 0x11 then 0x22 in order.
REQ-022 Forwarding: pending addr 7=0xAA then addr 7=0xBB -> q_addr=7 gives q_hit=1, q_data=0xBB; q_addr=8 gives q_hit=0, q_data=0.
REQ-023 Zero register/no-write: push addr 0 we=1 and addr 9 we=0 -> both accepted, count stays 0, rf_valid never asserts.
REQ-024 Flush and reset: count=2, flush=1 with simultaneous in_valid and rf_ready -> count=0 next cycle, no rf pop counted; separately assert reset asynchronously between edges at count=1 -> outputs zero immediately.
REQ-025 Generic source: NSRC=4, in_sel=2, src2=0x1234_5678, in_sel=5 case at NSRC=5 out-of-range via in_sel=6 -> rf_data=0x1234_5678 then 0.
